// File: rtl/network_mac_pipe_s_u.sv
// Pipelined signed x unsigned multiply-accumulate with clock enable, framed accumulation
// and round/shift/saturate output formatting.
module network_mac_pipe_s_u #(
    parameter int A_W       = 16,
    parameter int B_W       = 14,
    parameter int ACC_W     = 36,
    parameter int SHIFT     = 0,
    parameter int OUT_W     = 30,
    parameter int NUM_STAGE = 3
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic             acc_mode,
    input  logic             acc_first,
    input  logic             acc_last,
    output logic             out_valid,
    output logic [OUT_W-1:0] dout,
    output logic             ovf
);

    localparam int P_W = A_W + B_W;
    localparam int NS  = NUM_STAGE - 1;

    localparam logic [ACC_W:0] RND = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W - 1){1'b0}}};

    // Round half toward +inf, arithmetic shift, then saturate; returns {ovf, dout}.
    function automatic logic [OUT_W:0] fmt_out(input logic [ACC_W-1:0] v);
        logic signed [ACC_W:0] x_s;
        logic signed [ACC_W:0] r_s;
        x_s = $signed({v[ACC_W-1], v}) + $signed(RND);
        r_s = x_s >>> SHIFT;
        if (r_s > MAXV) begin
            fmt_out = {1'b1, OMAX};
        end else if (r_s < MINV) begin
            fmt_out = {1'b1, OMIN};
        end else begin
            fmt_out = {1'b0, r_s[OUT_W-1:0]};
        end
    endfunction

    logic [A_W-1:0]   a_r;
    logic [B_W-1:0]   b_r;
    logic [NS-1:0]    vld_r;
    logic [NS-1:0]    mode_r;
    logic [NS-1:0]    first_r;
    logic [NS-1:0]    last_r;
    logic [P_W-1:0]   prod_s;
    logic [P_W-1:0]   fprod_s;
    logic [ACC_W-1:0] pext_s;
    logic [ACC_W-1:0] next_s;
    logic             emit_s;
    logic [OUT_W:0]   fmt_s;
    logic [ACC_W-1:0] acc_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] dout_r;
    logic             ovf_r;

    // Stage 1 operand capture plus valid/flag shift chain through all pipe stages.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_r     <= '0;
            b_r     <= '0;
            vld_r   <= '0;
            mode_r  <= '0;
            first_r <= '0;
            last_r  <= '0;
        end else if (ce) begin
            if (in_valid) begin
                a_r <= din0;
                b_r <= din1;
            end
            vld_r[0]   <= in_valid;
            mode_r[0]  <= acc_mode;
            first_r[0] <= acc_first;
            last_r[0]  <= acc_last;
            for (int i = 1; i < NS; i++) begin
                vld_r[i]   <= vld_r[i-1];
                mode_r[i]  <= mode_r[i-1];
                first_r[i] <= first_r[i-1];
                last_r[i]  <= last_r[i-1];
            end
        end
    end

    // Zero-extended din1 keeps the product non-negative-scaled; P_W bits hold it exactly.
    assign prod_s = $signed({{B_W{a_r[A_W-1]}}, a_r}) * $signed({{A_W{1'b0}}, b_r});

    generate
        if (NS >= 2) begin : g_prod_pipe
            logic [P_W-1:0] pp_r [NS-1];
            // Product delay line for stages 2..NUM_STAGE-1.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    for (int i = 0; i < NS - 1; i++) begin
                        pp_r[i] <= '0;
                    end
                end else if (ce) begin
                    pp_r[0] <= prod_s;
                    for (int i = 1; i < NS - 1; i++) begin
                        pp_r[i] <= pp_r[i-1];
                    end
                end
            end
            assign fprod_s = pp_r[NS-2];
        end else begin : g_prod_direct
            assign fprod_s = prod_s;
        end
    endgenerate

    // Final-stage accumulate and emit decision.
    always_comb begin
        pext_s = {{(ACC_W - P_W){fprod_s[P_W-1]}}, fprod_s};
        next_s = acc_r + pext_s;
        emit_s = 1'b0;
        if (!mode_r[NS-1] || first_r[NS-1]) begin
            next_s = pext_s;
        end else begin
            next_s = acc_r + pext_s;
        end
        if (vld_r[NS-1] && (!mode_r[NS-1] || last_r[NS-1])) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
        fmt_s = fmt_out(next_s);
    end

    // Accumulator and registered outputs; dout/ovf hold between emitted results.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            ovf_r       <= 1'b0;
        end else if (ce) begin
            out_valid_r <= emit_s;
            if (vld_r[NS-1]) begin
                acc_r <= next_s;
            end
            if (emit_s) begin
                ovf_r  <= fmt_s[OUT_W];
                dout_r <= fmt_s[OUT_W-1:0];
            end
        end
    end

    assign out_valid = out_valid_r;
    assign dout      = dout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_network_mac_pipe_s_u.sv
// Randomized self-checking bench: default-parameter MAC and a SHIFT=4/OUT_W=16/ACC_W=32 variant,
// both compared every cycle against a queue-based arithmetic model.
module tb_network_mac_pipe_s_u;

    localparam int NSTG = 3;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] din0 = '0;
    logic [13:0] din1 = '0;
    logic        acc_mode = 1'b0;
    logic        acc_first = 1'b0;
    logic        acc_last = 1'b0;
    logic        out_valid0, out_valid1;
    logic [29:0] dout0;
    logic [15:0] dout1;
    logic        ovf0, ovf1;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit e;
        int d;
        bit o;
    } ent_t;

    int     aw [2] = '{36, 32};
    int     sh [2] = '{0, 4};
    int     ow [2] = '{30, 16};
    longint acc_m [2];
    bit     ev [2];
    int     ed [2];
    bit     eo [2];
    ent_t   q0 [$];
    ent_t   q1 [$];

    always #5 ap_clk = ~ap_clk;

    network_mac_pipe_s_u dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .acc_mode(acc_mode), .acc_first(acc_first),
        .acc_last(acc_last), .out_valid(out_valid0), .dout(dout0), .ovf(ovf0)
    );

    network_mac_pipe_s_u #(.ACC_W(32), .SHIFT(4), .OUT_W(16)) dut_r (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .acc_mode(acc_mode), .acc_first(acc_first),
        .acc_last(acc_last), .out_valid(out_valid1), .dout(dout1), .ovf(ovf1)
    );

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint wrapv(input longint v, input int w);
        longint m;
        longint x;
        m = longint'(1) << w;
        x = v & (m - longint'(1));
        if (x >= (m >>> 1)) x = x - m;
        return x;
    endfunction

    task automatic fmt(input longint n, input int s, input int w, output int d, output bit o);
        longint r, mx, mn;
        r = n;
        if (s > 0) r = r + (longint'(1) << (s - 1));
        r = r >>> s;
        mx = (longint'(1) << (w - 1)) - longint'(1);
        mn = -(longint'(1) << (w - 1));
        if (r > mx) begin
            d = int'(mx); o = 1'b1;
        end else if (r < mn) begin
            d = int'(mn); o = 1'b1;
        end else begin
            d = int'(r); o = 1'b0;
        end
    endtask

    task automatic mk(input int m, output ent_t e);
        longint p;
        e.e = 1'b0; e.d = 0; e.o = 1'b0;
        if (in_valid) begin
            p = longint'($signed(din0)) * longint'(din1);
            if (!acc_mode || acc_first) acc_m[m] = wrapv(p, aw[m]);
            else acc_m[m] = wrapv(acc_m[m] + p, aw[m]);
            if (!acc_mode || acc_last) begin
                e.e = 1'b1;
                fmt(acc_m[m], sh[m], ow[m], e.d, e.o);
            end
        end
    endtask

    // Model of one rising edge: results leave the queue NUM_STAGE-1 enabled edges after entry.
    task automatic model_edge();
        ent_t e0, e1, b;
        b.e = 1'b0; b.d = 0; b.o = 1'b0;
        if (ap_rst) begin
            q0.delete(); q1.delete();
            for (int m = 0; m < 2; m++) begin
                acc_m[m] = 0; ev[m] = 1'b0; ed[m] = 0; eo[m] = 1'b0;
            end
            for (int i = 0; i < NSTG - 1; i++) begin
                q0.push_back(b); q1.push_back(b);
            end
        end else if (ce) begin
            mk(0, e0); mk(1, e1);
            q0.push_back(e0); q1.push_back(e1);
            e0 = q0.pop_front(); e1 = q1.pop_front();
            ev[0] = e0.e; ev[1] = e1.e;
            if (e0.e) begin ed[0] = e0.d; eo[0] = e0.o; end
            if (e1.e) begin ed[1] = e1.d; eo[1] = e1.o; end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input int a, input int b,
                        input bit m, input bit f, input bit l);
        ap_rst = r; ce = c; in_valid = v;
        din0 = a[15:0]; din1 = b[13:0];
        acc_mode = m; acc_first = f; acc_last = l;
        @(posedge ap_clk);
        model_edge();
        @(negedge ap_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge ap_clk) begin
        if (chk_en) begin
            cmp("out_valid", int'(out_valid0), int'(ev[0]));
            cmp("dout", int'($signed(dout0)), ed[0]);
            cmp("ovf", int'(ovf0), int'(eo[0]));
            cmp("out_valid_r", int'(out_valid1), int'(ev[1]));
            cmp("dout_r", int'($signed(dout1)), ed[1]);
            cmp("ovf_r", int'(ovf1), int'(eo[1]));
        end
    end

    initial begin
        int a, b;
        bit r, c, v, m, f, l;
        @(negedge ap_clk);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        cmp("rst_out_valid", int'(out_valid0), 0);
        cmp("rst_dout", int'($signed(dout0)), 0);

        // Mode 0 extreme product, then back-to-back samples
        step(1'b0, 1'b1, 1'b1, -32768, 16383, 1'b0, 1'b0, 1'b0);
        idle(1);
        cmp("lat_early", int'(out_valid0), 0);
        idle(1);
        cmp("mul_valid", int'(out_valid0), 1);
        cmp("mul_dout", int'($signed(dout0)), -536838144);
        cmp("mul_ovf", int'(ovf0), 0);
        cmp("model_mul", ed[0], -536838144);
        cmp("mul_sat_r", int'($signed(dout1)), -32768);
        step(1'b0, 1'b1, 1'b1, 3, 4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, -7, 9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 100, 200, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Four-term accumulation
        step(1'b0, 1'b1, 1'b1, 1000, 1000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1000, 1000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1000, 1000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1000, 1000, 1'b1, 1'b0, 1'b1);
        idle(2);
        cmp("acc4_dout", int'($signed(dout0)), 4000000);
        cmp("model_acc4", ed[0], 4000000);
        idle(1);

        // Saturation, then recovery in mode 0
        step(1'b0, 1'b1, 1'b1, -32768, 16383, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, -32768, 16383, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
        idle(1);
        cmp("sat_dout", int'($signed(dout0)), -536870912);
        cmp("sat_ovf", int'(ovf0), 1);
        idle(1);
        cmp("unsat_dout", int'($signed(dout0)), 1);
        cmp("unsat_ovf", int'(ovf0), 0);

        // Rounding on the shifted variant
        step(1'b0, 1'b1, 1'b1, 25, 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, -24, 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16, 1, 1'b0, 1'b0, 1'b0);
        cmp("rnd_25", int'($signed(dout1)), 2);
        idle(1);
        cmp("rnd_m24", int'($signed(dout1)), -1);
        idle(1);
        cmp("rnd_16", int'($signed(dout1)), 1);
        cmp("model_rnd", ed[1], 1);

        // Stall with ce toggling; data offered during ce=0 must be ignored
        step(1'b0, 1'b1, 1'b1, 7, 3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 99, 99, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 98, 98, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, -5, 9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 11, 2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Reset mid-operation (with ce low), then sum starting without acc_first
        step(1'b0, 1'b1, 1'b1, 100, 100, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(4);
        cmp("rst_quiet", int'(out_valid0), 0);
        step(1'b0, 1'b1, 1'b1, 3, 5, 1'b1, 1'b0, 1'b1);
        idle(2);
        cmp("post_rst_sum", int'($signed(dout0)), 15);
        cmp("post_rst_valid", int'(out_valid0), 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 9) < 7);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                a = -32768; b = 16383;
            end
            m = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 3) == 0);
            step(r, c, v, a, b, m, f, l);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
